// File: rtl/hazard_ctrl.sv
// Hazard and pipeline-control unit for the 5-stage RV32I core: load-use and
// branch-operand stalls, data-memory freeze, redirect flush and a stall counter.
module hazard_ctrl #(
    parameter int AW              = 5,
    parameter int LOAD_USE_CYCLES = 1,
    parameter int BR_IN_ID        = 1,
    parameter int IMEM_LAT        = 1,
    parameter int PERF_W          = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [6:0]        id_opcode,
    input  logic [AW-1:0]     id_rs1,
    input  logic [AW-1:0]     id_rs2,
    input  logic [AW-1:0]     ex_rd,
    input  logic              ex_reg_we,
    input  logic              ex_is_load,
    input  logic [AW-1:0]     mem_rd,
    input  logic              mem_is_load,
    input  logic              ctrl_pc_src,
    input  logic              dmem_busy,
    output logic              ctrl_pc_en,
    output logic              ctrl_imem_en,
    output logic              if_id_en,
    output logic              ctrl_id_reg_flush,
    output logic              id_ex_en,
    output logic              ctrl_zero_sel,
    output logic              ex_mem_en,
    output logic              stall_active,
    output logic [PERF_W-1:0] stall_cycles
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam bit         BR_EN    = (BR_IN_ID != 0);
    localparam bit         LU_MULTI = (LOAD_USE_CYCLES > 1);
    localparam logic [2:0] LU_INIT  = 3'(LOAD_USE_CYCLES - 1);

    typedef enum logic {RUN, LU_STALL} state_t;

    state_t              state, state_nx;
    logic [2:0]          cnt, cnt_nx;
    logic [IMEM_LAT-1:0] flush_q, flush_nx;
    logic                use_rs1, use_rs2;
    logic                ex_match, mem_match;
    logic                lu, bh, stall;

    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (id_opcode)
            OPC_OP, OPC_STORE, OPC_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OPC_OPIMM, OPC_LOAD, OPC_JALR: use_rs1 = 1'b1;
            default: ;
        endcase
    end

    // x0 is never a real producer, so a zero rd can never create a dependency.
    assign ex_match  = (ex_rd != '0) &&
                       ((use_rs1 && id_rs1 == ex_rd) || (use_rs2 && id_rs2 == ex_rd));
    assign mem_match = (mem_rd != '0) &&
                       ((use_rs1 && id_rs1 == mem_rd) || (use_rs2 && id_rs2 == mem_rd));

    assign lu    = ex_is_load && ex_reg_we && ex_match;
    assign bh    = BR_EN && (id_opcode == OPC_BRANCH || id_opcode == OPC_JALR) &&
                   ((ex_reg_we && ex_match) || (mem_is_load && mem_match));
    assign stall = (lu || bh || state == LU_STALL) && !ctrl_pc_src;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= 3'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (!dmem_busy) begin
            if (ctrl_pc_src) begin
                state_nx = RUN;
                cnt_nx   = 3'd0;
            end else if (state == LU_STALL) begin
                cnt_nx = cnt - 3'd1;
                if (cnt == 3'd1) state_nx = RUN;
            end else if (lu && LU_MULTI) begin
                state_nx = LU_STALL;
                cnt_nx   = LU_INIT;
            end
        end
    end

    always_comb begin
        ctrl_pc_en    = 1'b1;
        ctrl_imem_en  = 1'b1;
        if_id_en      = 1'b1;
        id_ex_en      = 1'b1;
        ex_mem_en     = 1'b1;
        ctrl_zero_sel = (id_opcode == 7'd0);
        stall_active  = 1'b0;
        if (rst) begin
            // imem stays enabled so the reset PC is already being fetched
            ctrl_pc_en    = 1'b0;
            ctrl_zero_sel = 1'b1;
            ex_mem_en     = 1'b0;
        end else if (dmem_busy) begin
            ctrl_pc_en    = 1'b0;
            ctrl_imem_en  = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            ctrl_zero_sel = 1'b0;
            stall_active  = 1'b1;
        end else if (ctrl_pc_src) begin
            ctrl_zero_sel = 1'b1;
        end else if (stall) begin
            ctrl_pc_en    = 1'b0;
            ctrl_imem_en  = 1'b0;
            if_id_en      = 1'b0;
            ctrl_zero_sel = 1'b1;
            stall_active  = 1'b1;
        end
    end

    // One bit per outstanding wrong-path fetch still inside the imem pipeline.
    always_comb begin
        flush_nx    = '0;
        flush_nx[0] = ctrl_imem_en && ctrl_pc_src;
        for (int i = 1; i < IMEM_LAT; i++) flush_nx[i] = flush_q[i-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)             flush_q <= '1;
        else if (!dmem_busy) flush_q <= flush_nx;
    end

    assign ctrl_id_reg_flush = rst || (|flush_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cycles <= '0;
        else if (stall_active && stall_cycles != '1)
            stall_cycles <= stall_cycles + 1'b1;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed vector table, hand-written reset/saturation
// sequences and randomized traffic against an abstract cycle model.
module tb_hazard_ctrl;

    localparam logic [6:0] OP_C    = 7'h33;
    localparam logic [6:0] OPI_C   = 7'h13;
    localparam logic [6:0] LD_C    = 7'h03;
    localparam logic [6:0] ST_C    = 7'h23;
    localparam logic [6:0] BR_C    = 7'h63;
    localparam logic [6:0] JALR_C  = 7'h67;
    localparam logic [6:0] LUI_C   = 7'h37;
    localparam logic [6:0] AUIPC_C = 7'h17;
    localparam logic [6:0] JAL_C   = 7'h6f;

    typedef struct {
        logic       rst;
        logic [6:0] op;
        logic [4:0] rs1, rs2, ex_rd, mem_rd;
        logic       ex_we, ex_ld, mem_ld, pc_src, busy;
    } in_t;

    typedef struct {
        int              remain;
        int              flush_left;
        longint unsigned perf;
    } ms_t;

    typedef struct {
        in_t        stim;
        logic [7:0] e_out;
        int         e_perf;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] id_opcode = '0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0, mem_rd = '0;
    logic       ex_reg_we = 1'b0, ex_is_load = 1'b0, mem_is_load = 1'b0;
    logic       ctrl_pc_src = 1'b0, dmem_busy = 1'b0;

    logic        a_pc_en, a_imem_en, a_if_id_en, a_flush, a_id_ex_en, a_zero, a_ex_mem_en, a_stall;
    logic [31:0] a_stall_cycles;
    logic        b_pc_en, b_imem_en, b_if_id_en, b_flush, b_id_ex_en, b_zero, b_ex_mem_en, b_stall;
    logic [3:0]  b_stall_cycles;
    logic [7:0]  a_out, b_out;

    vec_t       tbl[$];
    ms_t        ma, mb;
    int         tests = 0;
    int         fails = 0;
    logic [6:0] ops [0:9];

    always #5 clk = ~clk;

    hazard_ctrl #(.AW(5), .LOAD_USE_CYCLES(2), .BR_IN_ID(1), .IMEM_LAT(2), .PERF_W(32)) dut_a (
        .clk(clk), .rst(rst), .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_rd(ex_rd), .ex_reg_we(ex_reg_we), .ex_is_load(ex_is_load),
        .mem_rd(mem_rd), .mem_is_load(mem_is_load), .ctrl_pc_src(ctrl_pc_src),
        .dmem_busy(dmem_busy), .ctrl_pc_en(a_pc_en), .ctrl_imem_en(a_imem_en),
        .if_id_en(a_if_id_en), .ctrl_id_reg_flush(a_flush), .id_ex_en(a_id_ex_en),
        .ctrl_zero_sel(a_zero), .ex_mem_en(a_ex_mem_en), .stall_active(a_stall),
        .stall_cycles(a_stall_cycles)
    );

    hazard_ctrl #(.AW(5), .LOAD_USE_CYCLES(3), .BR_IN_ID(0), .IMEM_LAT(1), .PERF_W(4)) dut_b (
        .clk(clk), .rst(rst), .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_rd(ex_rd), .ex_reg_we(ex_reg_we), .ex_is_load(ex_is_load),
        .mem_rd(mem_rd), .mem_is_load(mem_is_load), .ctrl_pc_src(ctrl_pc_src),
        .dmem_busy(dmem_busy), .ctrl_pc_en(b_pc_en), .ctrl_imem_en(b_imem_en),
        .if_id_en(b_if_id_en), .ctrl_id_reg_flush(b_flush), .id_ex_en(b_id_ex_en),
        .ctrl_zero_sel(b_zero), .ex_mem_en(b_ex_mem_en), .stall_active(b_stall),
        .stall_cycles(b_stall_cycles)
    );

    // Output vector order: {pc_en, imem_en, if_id_en, flush, id_ex_en, zero_sel, ex_mem_en, stall_active}
    assign a_out = {a_pc_en, a_imem_en, a_if_id_en, a_flush, a_id_ex_en, a_zero, a_ex_mem_en, a_stall};
    assign b_out = {b_pc_en, b_imem_en, b_if_id_en, b_flush, b_id_ex_en, b_zero, b_ex_mem_en, b_stall};

    function automatic bit uses_rs1(input logic [6:0] op);
        return op inside {OP_C, OPI_C, LD_C, ST_C, BR_C, JALR_C};
    endfunction

    function automatic bit uses_rs2(input logic [6:0] op);
        return op inside {OP_C, ST_C, BR_C};
    endfunction

    function automatic bit hits(input in_t v, input logic [4:0] rd);
        return (rd != 0) && ((uses_rs1(v.op) && v.rs1 == rd) || (uses_rs2(v.op) && v.rs2 == rd));
    endfunction

    function automatic void get_hz(input in_t v, input int br, output bit lu, output bit bh);
        lu = v.ex_ld && v.ex_we && hits(v, v.ex_rd);
        bh = (br != 0) && (v.op == BR_C || v.op == JALR_C) &&
             ((v.ex_we && hits(v, v.ex_rd)) || (v.mem_ld && hits(v, v.mem_rd)));
    endfunction

    function automatic ms_t ms_reset(input int lat);
        ms_t s;
        s.remain     = 0;
        s.flush_left = lat;
        s.perf       = 0;
        return s;
    endfunction

    function automatic logic [7:0] model_out(input ms_t s, input in_t v, input int br);
        bit lu, bh, stall, fl;
        get_hz(v, br, lu, bh);
        stall = (lu || bh || s.remain > 0) && !v.pc_src;
        fl    = (s.flush_left > 0);
        if (v.rst)    return 8'b0111_1100;
        if (v.busy)   return {3'b000, fl, 4'b0001};
        if (v.pc_src) return {3'b111, fl, 4'b1110};
        if (stall)    return {3'b000, fl, 4'b1111};
        return {3'b111, fl, 1'b1, (v.op == 7'd0), 2'b10};
    endfunction

    function automatic ms_t model_next(input ms_t s, input in_t v, input int luc,
                                       input int br, input int lat, input int pw);
        ms_t n;
        bit lu, bh, stall;
        longint unsigned top;
        if (v.rst) return ms_reset(lat);
        n = s;
        get_hz(v, br, lu, bh);
        stall = (lu || bh || s.remain > 0) && !v.pc_src;
        top   = (64'd1 << pw) - 64'd1;
        if ((stall || v.busy) && s.perf < top) n.perf = s.perf + 1;
        if (!v.busy) begin
            if (v.pc_src) begin
                n.remain     = 0;
                n.flush_left = lat;
            end else begin
                n.remain     = (s.remain > 0) ? s.remain - 1 : (lu ? luc - 1 : 0);
                n.flush_left = (s.flush_left > 0) ? s.flush_left - 1 : 0;
            end
        end
        return n;
    endfunction

    function automatic in_t mk_in(input int r, input int op, input int rs1, input int rs2,
                                  input int erd, input int ewe, input int eld,
                                  input int mrd, input int mld, input int pcs, input int bsy);
        in_t v;
        v.rst = 1'(r);   v.op = 7'(op);     v.rs1 = 5'(rs1);    v.rs2 = 5'(rs2);
        v.ex_rd = 5'(erd); v.ex_we = 1'(ewe); v.ex_ld = 1'(eld);
        v.mem_rd = 5'(mrd); v.mem_ld = 1'(mld); v.pc_src = 1'(pcs); v.busy = 1'(bsy);
        return v;
    endfunction

    task automatic add_row(input in_t v, input logic [7:0] e, input int p);
        vec_t r;
        r.stim = v; r.e_out = e; r.e_perf = p;
        tbl.push_back(r);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input in_t v);
        rst = v.rst; id_opcode = v.op; id_rs1 = v.rs1; id_rs2 = v.rs2;
        ex_rd = v.ex_rd; ex_reg_we = v.ex_we; ex_is_load = v.ex_ld;
        mem_rd = v.mem_rd; mem_is_load = v.mem_ld; ctrl_pc_src = v.pc_src; dmem_busy = v.busy;
    endtask

    task automatic step(input in_t v, input bit use_tbl, input logic [7:0] texp,
                        input int tperf, input int idx);
        @(negedge clk);
        apply(v);
        if (v.rst) begin
            ma = ms_reset(2);
            mb = ms_reset(1);
        end
        #1;
        check("a_out", 64'(a_out), 64'(model_out(ma, v, 1)));
        check("a_perf", 64'(a_stall_cycles), ma.perf);
        check("b_out", 64'(b_out), 64'(model_out(mb, v, 0)));
        check("b_perf", 64'(b_stall_cycles), mb.perf);
        if (use_tbl) begin
            check($sformatf("tbl_out[%0d]", idx), 64'(a_out), 64'(texp));
            check($sformatf("tbl_perf[%0d]", idx), 64'(a_stall_cycles), 64'(tperf));
        end
        @(posedge clk);
        ma = model_next(ma, v, 2, 1, 2, 32);
        mb = model_next(mb, v, 3, 0, 1, 4);
    endtask

    initial begin
        in_t v;
        ma = ms_reset(2);
        mb = ms_reset(1);
        ops = '{7'h00, LUI_C, AUIPC_C, JAL_C, OP_C, OPI_C, LD_C, ST_C, BR_C, JALR_C};

        //          rst op      rs1 rs2 erd ewe eld mrd mld pcs bsy      expected     perf
        add_row(mk_in(1, 0,      0, 0, 0, 0, 0, 0, 0, 0, 0), 8'b0111_1100, 0);
        add_row(mk_in(0, 0,      0, 0, 0, 0, 0, 0, 0, 0, 0), 8'b1111_1110, 0);
        add_row(mk_in(0, 0,      0, 0, 0, 0, 0, 0, 0, 0, 0), 8'b1111_1110, 0);
        add_row(mk_in(0, 0,      0, 0, 0, 0, 0, 0, 0, 0, 0), 8'b1110_1110, 0);
        add_row(mk_in(0, OP_C,   1, 2, 1, 1, 1, 0, 0, 0, 0), 8'b0000_1111, 0);
        add_row(mk_in(0, OP_C,   1, 2, 0, 0, 0, 1, 1, 0, 0), 8'b0000_1111, 1);
        add_row(mk_in(0, OP_C,   1, 2, 0, 0, 0, 0, 0, 0, 0), 8'b1110_1010, 2);
        add_row(mk_in(0, BR_C,   5, 0, 5, 1, 0, 0, 0, 0, 0), 8'b0000_1111, 2);
        add_row(mk_in(0, BR_C,   5, 0, 0, 1, 0, 0, 0, 0, 0), 8'b1110_1010, 3);
        add_row(mk_in(0, OP_C,   1, 2, 1, 1, 1, 0, 0, 1, 0), 8'b1110_1110, 3);
        add_row(mk_in(0, 0,      0, 0, 0, 0, 0, 0, 0, 0, 0), 8'b1111_1110, 3);
        add_row(mk_in(0, 0,      0, 0, 0, 0, 0, 0, 0, 0, 0), 8'b1111_1110, 3);
        add_row(mk_in(0, 0,      0, 0, 0, 0, 0, 0, 0, 0, 0), 8'b1110_1110, 3);
        add_row(mk_in(0, OP_C,   1, 2, 1, 1, 1, 0, 0, 0, 0), 8'b0000_1111, 3);
        add_row(mk_in(0, OP_C,   1, 2, 0, 0, 0, 1, 1, 0, 1), 8'b0000_0001, 4);
        add_row(mk_in(0, OP_C,   1, 2, 0, 0, 0, 1, 1, 0, 1), 8'b0000_0001, 5);
        add_row(mk_in(0, OP_C,   1, 2, 0, 0, 0, 1, 1, 0, 1), 8'b0000_0001, 6);
        add_row(mk_in(0, OP_C,   1, 2, 0, 0, 0, 1, 1, 0, 0), 8'b0000_1111, 7);
        add_row(mk_in(0, OP_C,   1, 2, 0, 0, 0, 0, 0, 0, 0), 8'b1110_1010, 8);
        add_row(mk_in(0, 0,      0, 0, 0, 0, 0, 0, 0, 1, 0), 8'b1110_1110, 8);
        add_row(mk_in(0, 0,      0, 0, 0, 0, 0, 0, 0, 0, 1), 8'b0001_0001, 8);
        add_row(mk_in(0, 0,      0, 0, 0, 0, 0, 0, 0, 0, 0), 8'b1111_1110, 9);
        add_row(mk_in(0, 0,      0, 0, 0, 0, 0, 0, 0, 0, 0), 8'b1111_1110, 9);
        add_row(mk_in(0, 0,      0, 0, 0, 0, 0, 0, 0, 0, 0), 8'b1110_1110, 9);
        add_row(mk_in(0, BR_C,   5, 0, 0, 0, 0, 5, 1, 0, 0), 8'b0000_1111, 9);
        add_row(mk_in(0, JALR_C, 7, 0, 7, 1, 0, 0, 0, 0, 0), 8'b0000_1111, 10);
        add_row(mk_in(0, LUI_C,  1, 0, 1, 1, 1, 0, 0, 0, 0), 8'b1110_1010, 11);
        add_row(mk_in(0, ST_C,   0, 4, 4, 1, 1, 0, 0, 0, 0), 8'b0000_1111, 11);
        add_row(mk_in(0, ST_C,   0, 4, 0, 0, 0, 0, 0, 0, 0), 8'b0000_1111, 12);
        add_row(mk_in(0, 0,      0, 0, 0, 0, 0, 0, 0, 0, 0), 8'b1110_1110, 13);

        for (int r = 0; r < tbl.size(); r++)
            step(tbl[r].stim, 1'b1, tbl[r].e_out, tbl[r].e_perf, r);

        // Asynchronous reset in the middle of a multi-cycle load-use stall.
        step(mk_in(0, OP_C, 1, 2, 1, 1, 1, 0, 0, 0, 0), 1'b0, 8'h00, 0, 0);
        #3;
        rst = 1'b1;
        #1;
        check("rst_async_stall", 64'(a_stall), 64'd0);
        check("rst_async_flush", 64'(a_flush), 64'd1);
        check("rst_async_pc_en", 64'(a_pc_en), 64'd0);
        check("rst_async_perf", 64'(a_stall_cycles), 64'd0);
        ma = ms_reset(2);
        mb = ms_reset(1);
        step(mk_in(1, 0,    0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 8'h00, 0, 0);
        step(mk_in(0, OP_C, 1, 2, 0, 0, 0, 0, 0, 0, 0), 1'b0, 8'h00, 0, 0);
        #1;
        check("rst_no_residual", 64'(a_stall_cycles), 64'd0);

        // Long freeze drives the 4-bit counter of dut_b into saturation.
        for (int k = 0; k < 20; k++)
            step(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 1'b0, 8'h00, 0, 0);
        #1;
        check("b_perf_sat", 64'(b_stall_cycles), 64'd15);

        step(mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 8'h00, 0, 0);
        for (int k = 0; k < 1500; k++) begin
            v.rst    = ($urandom_range(0, 59) == 0);
            v.op     = ops[$urandom_range(0, 9)];
            v.rs1    = 5'($urandom_range(0, 3));
            v.rs2    = 5'($urandom_range(0, 3));
            v.ex_rd  = 5'($urandom_range(0, 3));
            v.mem_rd = 5'($urandom_range(0, 3));
            v.ex_we  = 1'($urandom_range(0, 1));
            v.ex_ld  = 1'($urandom_range(0, 1));
            v.mem_ld = 1'($urandom_range(0, 1));
            v.pc_src = ($urandom_range(0, 9) == 0);
            v.busy   = ($urandom_range(0, 6) == 0);
            step(v, 1'b0, 8'h00, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
